// File: rtl/rf_seq_ctrl_pkg.sv
// rf_seq_pkg: shared types and sizing for the systolic-array register-file sequencer.
package rf_seq_pkg;

  localparam int N          = 8;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int STAT_W     = 4;

  localparam int NUM_FIFO = 2 * N;
  localparam int STATUS_W = NUM_FIFO * STAT_W;
  localparam int NN       = N * N;
  localparam int SKEW     = 2 * N - 2;

  localparam int LOAD_W  = $clog2(NN);
  localparam int SLICE_W = $clog2(N);
  localparam int SKEW_W  = $clog2(SKEW + 1);

  localparam logic [LOAD_W-1:0]  LAST_LOAD  = LOAD_W'(NN - 1);
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(N - 1);
  localparam logic [SKEW_W-1:0]  SKEW_INIT  = SKEW_W'(SKEW);
  localparam logic [STAT_W-1:0]  NEAR_FULL  = STAT_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PUSH,
    DRAIN,
    FLUSH
  } rf_seq_state_t;

  // Widen a load counter into a full RF word address.
  function automatic logic [ADDR_W-1:0] zext_addr(input logic [LOAD_W-1:0] v);
    return {{(ADDR_W - LOAD_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/rf_seq_ctrl_if.sv
// rf_seq_ctrl_if: host stream, RF write port and FIFO control bundle of the sequencer.
interface rf_seq_ctrl_if;
  import rf_seq_pkg::*;

  logic                i_start;
  logic                o_busy;
  logic                o_done;
  logic [DATA_W-1:0]   i_in_data;
  logic                i_in_valid;
  logic                o_in_ready;
  logic                o_rf_enable;
  logic                o_rf_write;
  logic                o_fifo_write;
  logic                o_fifo_enable;
  logic [ADDR_W-1:0]   o_addr;
  logic [DATA_W-1:0]   o_data;
  logic [STATUS_W-1:0] i_fifo_status;

  modport master (
    output i_start, i_in_data, i_in_valid, i_fifo_status,
    input  o_busy, o_done, o_in_ready, o_rf_enable, o_rf_write,
           o_fifo_write, o_fifo_enable, o_addr, o_data
  );

  modport slave (
    input  i_start, i_in_data, i_in_valid, i_fifo_status,
    output o_busy, o_done, o_in_ready, o_rf_enable, o_rf_write,
           o_fifo_write, o_fifo_enable, o_addr, o_data
  );

endinterface

// File: rtl/rf_seq_ctrl_fifo_mon.sv
// rf_fifo_mon: folds the per-FIFO occupancy counts into the two flags the sequencer acts on.
module rf_fifo_mon
  import rf_seq_pkg::*;
(
  input  logic [STATUS_W-1:0] i_fifo_status,
  output logic                o_all_empty,
  output logic                o_any_near_full
);

  // Scan every feed FIFO: empty only if all are zero, near-full if any can take at most one more.
  always_comb begin
    o_all_empty     = 1'b1;
    o_any_near_full = 1'b0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (i_fifo_status[i*STAT_W +: STAT_W] != '0) begin
        o_all_empty = 1'b0;
      end
      if (i_fifo_status[i*STAT_W +: STAT_W] >= NEAR_FULL) begin
        o_any_near_full = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: loads an NxN matrix into the RF, pushes its slices into the feed FIFOs,
// drains them into the array and waits out the array skew before signalling completion.
module rf_seq_ctrl
  import rf_seq_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  rf_seq_ctrl_if.slave bus
);

  rf_seq_state_t       r_state, w_state_nx;
  logic                r_busy, w_busy_nx;
  logic                r_done, w_done_nx;
  logic                r_in_ready, w_in_ready_nx;
  logic                r_rf_enable, w_rf_enable_nx;
  logic                r_rf_write, w_rf_write_nx;
  logic                r_fifo_write, w_fifo_write_nx;
  logic                r_fifo_enable, w_fifo_enable_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_data, w_data_nx;
  logic [LOAD_W-1:0]   r_load_cnt, w_load_cnt_nx;
  logic [SLICE_W-1:0]  r_slice_cnt, w_slice_cnt_nx;
  logic [SKEW_W-1:0]   r_skew_cnt, w_skew_cnt_nx;

  logic w_all_empty;
  logic w_any_near_full;
  logic w_handshake;

  rf_fifo_mon u_fifo_mon (
    .i_fifo_status   (bus.i_fifo_status),
    .o_all_empty     (w_all_empty),
    .o_any_near_full (w_any_near_full)
  );

  assign w_handshake = bus.i_in_valid & r_in_ready;

  // State, counters and every output are held in registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_rf_enable   <= 1'b0;
      r_rf_write    <= 1'b0;
      r_fifo_write  <= 1'b0;
      r_fifo_enable <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_load_cnt    <= '0;
      r_slice_cnt   <= '0;
      r_skew_cnt    <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
      r_in_ready    <= w_in_ready_nx;
      r_rf_enable   <= w_rf_enable_nx;
      r_rf_write    <= w_rf_write_nx;
      r_fifo_write  <= w_fifo_write_nx;
      r_fifo_enable <= w_fifo_enable_nx;
      r_addr        <= w_addr_nx;
      r_data        <= w_data_nx;
      r_load_cnt    <= w_load_cnt_nx;
      r_slice_cnt   <= w_slice_cnt_nx;
      r_skew_cnt    <= w_skew_cnt_nx;
    end
  end

  // Job sequencing: strobes default low, levels and address/data hold unless a phase changes them.
  always_comb begin
    w_state_nx       = r_state;
    w_busy_nx        = r_busy;
    w_done_nx        = 1'b0;
    w_in_ready_nx    = r_in_ready;
    w_rf_enable_nx   = r_rf_enable;
    w_rf_write_nx    = 1'b0;
    w_fifo_write_nx  = 1'b0;
    w_fifo_enable_nx = r_fifo_enable;
    w_addr_nx        = r_addr;
    w_data_nx        = r_data;
    w_load_cnt_nx    = r_load_cnt;
    w_slice_cnt_nx   = r_slice_cnt;
    w_skew_cnt_nx    = r_skew_cnt;

    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_state_nx     = LOAD;
          w_busy_nx      = 1'b1;
          w_in_ready_nx  = 1'b1;
          w_rf_enable_nx = 1'b1;
          w_load_cnt_nx  = '0;
          w_slice_cnt_nx = '0;
          w_skew_cnt_nx  = '0;
        end
      end

      LOAD: begin
        if (w_handshake) begin
          w_rf_write_nx = 1'b1;
          w_addr_nx     = zext_addr(r_load_cnt);
          w_data_nx     = bus.i_in_data;
          w_load_cnt_nx = r_load_cnt + 1'b1;
          if (r_load_cnt == LAST_LOAD) begin
            w_state_nx    = PUSH;
            w_in_ready_nx = 1'b0;
          end
        end
      end

      PUSH: begin
        w_fifo_enable_nx = r_fifo_enable | r_fifo_write;
        if (!w_any_near_full) begin
          w_fifo_write_nx = 1'b1;
          w_addr_nx       = zext_addr({{(LOAD_W - SLICE_W){1'b0}}, r_slice_cnt});
          w_slice_cnt_nx  = r_slice_cnt + 1'b1;
          if (r_slice_cnt == LAST_SLICE) begin
            w_state_nx = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (w_all_empty) begin
          w_state_nx       = FLUSH;
          w_skew_cnt_nx    = SKEW_INIT;
          w_fifo_enable_nx = 1'b0;
        end else begin
          w_fifo_enable_nx = 1'b1;
        end
      end

      FLUSH: begin
        if (r_skew_cnt == '0) begin
          w_state_nx     = IDLE;
          w_done_nx      = 1'b1;
          w_busy_nx      = 1'b0;
          w_rf_enable_nx = 1'b0;
        end else begin
          w_skew_cnt_nx = r_skew_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_in_ready    = r_in_ready;
  assign bus.o_rf_enable   = r_rf_enable;
  assign bus.o_rf_write    = r_rf_write;
  assign bus.o_fifo_write  = r_fifo_write;
  assign bus.o_fifo_enable = r_fifo_enable;
  assign bus.o_addr        = r_addr;
  assign bus.o_data        = r_data;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: randomized and directed jobs checked every cycle against a job-level model.
module tb_rf_seq_ctrl;
  import rf_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rf_seq_ctrl_if bus ();

  rf_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  int st[NUM_FIFO];

  int mActive, mWords, mSlices, mFlush;
  logic mBusy, mDone, mInReady, mRfWrite, mFifoWrite, mFifoEnable;
  logic [31:0] mAddr;
  logic [15:0] mData;

  int rfWrites, fifoWrites, dones;
  int firstRf, lastRf, firstFifo, lastFifo, enFall, doneCycle;
  int tZero, drainCyc, bpLeft;
  bit aborted;
  logic prevEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cycleNo);
    end
  endtask

  task automatic driveStatus();
    for (int i = 0; i < NUM_FIFO; i++) begin
      bus.i_fifo_status[i*STAT_W +: STAT_W] = STAT_W'(st[i]);
    end
  endtask

  function automatic bit inLoad();
    return (mActive != 0) && (mWords < NN);
  endfunction

  function automatic bit inPush();
    return (mActive != 0) && (mWords == NN) && (mSlices < N);
  endfunction

  function automatic bit inDrain();
    return (mActive != 0) && (mSlices == N) && (mFlush < 0);
  endfunction

  task automatic modelReset();
    mActive = 0; mWords = 0; mSlices = 0; mFlush = -1;
    mBusy = 0; mDone = 0; mInReady = 0; mRfWrite = 0;
    mFifoWrite = 0; mFifoEnable = 0; mAddr = '0; mData = '0;
  endtask

  task automatic modelStep();
    bit prevPush;
    bit nearFull;
    bit allZero;
    prevPush = mFifoWrite;
    nearFull = 0;
    allZero  = 1;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (st[i] >= FIFO_DEPTH - 1) nearFull = 1;
      if (st[i] != 0) allZero = 0;
    end
    mDone = 0; mRfWrite = 0; mFifoWrite = 0;
    if (mActive == 0) begin
      if (bus.i_start) begin
        mActive = 1; mWords = 0; mSlices = 0; mFlush = -1;
        mBusy = 1; mInReady = 1;
      end
    end else if (mWords < NN) begin
      if (bus.i_in_valid) begin
        mRfWrite = 1;
        mAddr = 32'(mWords);
        mData = bus.i_in_data;
        mWords++;
        if (mWords == NN) mInReady = 0;
      end
    end else if (mSlices < N) begin
      if (prevPush) mFifoEnable = 1;
      if (!nearFull) begin
        mFifoWrite = 1;
        mAddr = 32'(mSlices);
        mSlices++;
      end
    end else if (mFlush < 0) begin
      if (allZero) begin
        mFlush = SKEW;
        mFifoEnable = 0;
      end else begin
        mFifoEnable = 1;
      end
    end else if (mFlush == 0) begin
      mActive = 0; mBusy = 0; mDone = 1;
    end else begin
      mFlush--;
    end
  endtask

  // Reference model: advances on each clock edge from the inputs the bench drove, resets asynchronously.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Compare process: every output against the model each cycle, plus event bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      cycleNo++;
      checkOutput("busy", 32'(bus.o_busy), 32'(mBusy));
      checkOutput("done", 32'(bus.o_done), 32'(mDone));
      checkOutput("in_ready", 32'(bus.o_in_ready), 32'(mInReady));
      checkOutput("rf_enable", 32'(bus.o_rf_enable), 32'(mBusy));
      checkOutput("rf_write", 32'(bus.o_rf_write), 32'(mRfWrite));
      checkOutput("fifo_write", 32'(bus.o_fifo_write), 32'(mFifoWrite));
      checkOutput("fifo_enable", 32'(bus.o_fifo_enable), 32'(mFifoEnable));
      checkOutput("addr", bus.o_addr, mAddr);
      checkOutput("data", 32'(bus.o_data), 32'(mData));
      checkOutput("write_excl", 32'(bus.o_rf_write & bus.o_fifo_write), 32'd0);
      if (bus.o_rf_write) begin
        rfWrites++;
        if (firstRf < 0) firstRf = cycleNo;
        lastRf = cycleNo;
      end
      if (bus.o_fifo_write) begin
        fifoWrites++;
        if (firstFifo < 0) firstFifo = cycleNo;
        lastFifo = cycleNo;
      end
      if (prevEn && !bus.o_fifo_enable) enFall = cycleNo;
      if (bus.o_done) begin
        dones++;
        doneCycle = cycleNo;
      end
      prevEn = bus.o_fifo_enable;
    end
  end

  task automatic clearCounters();
    rfWrites = 0; fifoWrites = 0; dones = 0;
    firstRf = -1; lastRf = -1; firstFifo = -1; lastFifo = -1;
    enFall = -1; doneCycle = -1; tZero = -1; drainCyc = 0; bpLeft = 4;
    aborted = 0;
  endtask

  // kind 0/3/4: gapless ordered data, 1: bubbly load with backpressure and stray STARTs, 2: random.
  task automatic applyStimulus(input int kind);
    bit zeroNow;
    zeroNow = 0;
    if (kind == 2) begin
      bus.i_in_valid = ($urandom_range(0, 3) != 0);
      bus.i_in_data  = 16'($urandom);
      if (mActive != 0) bus.i_start = ($urandom_range(0, 4) == 0);
    end else if (kind == 1) begin
      bus.i_in_valid = ((cycleNo % 3) != 0);
      bus.i_in_data  = inLoad() ? 16'(mWords) : 16'($urandom);
      if ((inLoad() && mWords == 10) || (inPush() && mSlices == 1)) bus.i_start = 1'b1;
    end else begin
      bus.i_in_valid = 1'b1;
      bus.i_in_data  = inLoad() ? 16'(mWords) : 16'($urandom);
    end

    for (int i = 0; i < NUM_FIFO; i++) st[i] = $urandom_range(1, 5);

    if (inPush()) begin
      if (kind == 1 && mSlices == 3 && bpLeft > 0) begin
        st[5] = FIFO_DEPTH - 1;
        bpLeft--;
      end else if (kind == 2 && $urandom_range(0, 3) == 0) begin
        st[$urandom_range(0, NUM_FIFO - 1)] = $urandom_range(FIFO_DEPTH - 1, FIFO_DEPTH);
      end
    end else if (inDrain()) begin
      if (kind == 2) begin
        zeroNow = ($urandom_range(0, 2) == 0);
      end else begin
        zeroNow = (drainCyc >= 3);
        drainCyc++;
      end
      if (zeroNow) begin
        for (int i = 0; i < NUM_FIFO; i++) st[i] = 0;
        tZero = cycleNo;
      end
    end
    driveStatus();
  endtask

  task automatic runJob(input int kind);
    clearCounters();
    @(negedge clk); #1;
    bus.i_start = 1'b1;
    applyStimulus(kind);
    for (int cyc = 0; cyc < 4000 && dones == 0 && !aborted; cyc++) begin
      @(negedge clk); #1;
      bus.i_start = 1'b0;
      applyStimulus(kind);
      if (kind == 3 && inPush() && mSlices == 3) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("async_ready", 32'(bus.o_in_ready), 32'd0);
        checkOutput("async_rf_en", 32'(bus.o_rf_enable), 32'd0);
        checkOutput("async_fifo_wr", 32'(bus.o_fifo_write), 32'd0);
        checkOutput("async_fifo_en", 32'(bus.o_fifo_enable), 32'd0);
        checkOutput("async_addr", bus.o_addr, 32'd0);
        checkOutput("async_data", 32'(bus.o_data), 32'd0);
        aborted = 1;
      end
    end
    if (dones == 0 && !aborted) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no done for job kind %0d, required 1 done", kind);
    end
    bus.i_start    = 1'b0;
    bus.i_in_valid = 1'b0;
    if (aborted) begin
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkGapless(input string tag);
    checkOutput({tag, "_rf_writes"}, 32'(rfWrites), 32'd64);
    checkOutput({tag, "_rf_run"}, 32'(lastRf - firstRf + 1), 32'd64);
    checkOutput({tag, "_first_addr_cycle"}, 32'(firstRf), 32'(firstRf));
    checkOutput({tag, "_fifo_writes"}, 32'(fifoWrites), 32'd8);
    checkOutput({tag, "_push_span"}, 32'(lastFifo - firstFifo + 1), 32'd8);
    checkOutput({tag, "_push_after_load"}, 32'(firstFifo), 32'(lastRf + 1));
    checkOutput({tag, "_en_fall"}, 32'(enFall), 32'(tZero + 1));
    checkOutput({tag, "_done_cycle"}, 32'(doneCycle), 32'(tZero + 16));
    checkOutput({tag, "_dones"}, 32'(dones), 32'd1);
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    for (int i = 0; i < NUM_FIFO; i++) st[i] = 2;
    driveStatus();
    clearCounters();

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.o_in_ready), 32'd0);
    checkOutput("rst_addr", bus.o_addr, 32'd0);
    checkOutput("rst_rf_en", 32'(bus.o_rf_enable), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] gapless job");
    runJob(0);
    checkGapless("gapless");

    $display("[TB] bubbly load, backpressure, START while busy");
    runJob(1);
    checkOutput("bubbly_rf_writes", 32'(rfWrites), 32'd64);
    checkOutput("bubbly_fifo_writes", 32'(fifoWrites), 32'd8);
    checkOutput("bubbly_push_after_load", 32'(firstFifo), 32'(lastRf + 1));
    checkOutput("bp_push_span", 32'(lastFifo - firstFifo + 1), 32'd12);
    checkOutput("bubbly_done_cycle", 32'(doneCycle), 32'(tZero + 16));
    checkOutput("bubbly_dones", 32'(dones), 32'd1);

    for (int j = 0; j < 4; j++) begin
      $display("[TB] random job %0d", j);
      runJob(2);
      checkOutput("rand_rf_writes", 32'(rfWrites), 32'd64);
      checkOutput("rand_fifo_writes", 32'(fifoWrites), 32'd8);
      checkOutput("rand_done_cycle", 32'(doneCycle), 32'(tZero + 16));
      checkOutput("rand_dones", 32'(dones), 32'd1);
    end

    $display("[TB] reset during PUSH");
    runJob(3);
    checkOutput("abort_dones", 32'(dones), 32'd0);

    $display("[TB] restart after reset");
    runJob(4);
    checkGapless("restart");

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
